// File: rtl/uart_mem_loader.sv
// uart_mem_loader: receives a program image over an 8N1 UART line and writes
// it word by word into the memory's write port while the core is held in reset.
// Image format: 4-byte little-endian word count N, then N words, each sent as
// 4 bytes little-endian, then a 1-byte XOR checksum of all the data bytes.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   Rx             UART receive line (idles high, asynchronous to clk)
//   Start          arms a load from IDLE/DONE/ERR
//   AddressOut     word-aligned byte address of the current write
//   WriteDataOut   write data
//   EnableWriteOut one-cycle write strobe
//   Busy           load in progress (LEN, DATA, CSUM)
//   Done           sticky: the image loaded and the checksum matched
//   Error          sticky: framing, length or checksum failure
//   WordCount      words written in the current load
module uart_mem_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MAX_WORDS    = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Rx,
    input  logic        Start,
    output logic [31:0] AddressOut,
    output logic [31:0] WriteDataOut,
    output logic        EnableWriteOut,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [14:0] WordCount
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} ld_state_t;

    // ---------------- Rx synchronizer and falling-edge detect ----------------
    logic rx_s1, rx_s2, rx_d;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= Rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end
    wire rx_fall = rx_d & ~rx_s2;

    // ---------------- UART receiver ----------------
    rx_state_t       rx_state, rx_next;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      rx_byte;
    logic            byte_valid, frame_err;

    wire half_tick = (clk_cnt == CW'(CLKS_PER_BIT / 2 - 1));
    wire full_tick = (clk_cnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            // Mid-start-bit re-sample rejects short low glitches.
            RX_START: if (half_tick) rx_next = rx_s2 ? RX_IDLE : RX_BITS;
            RX_BITS:  if (full_tick && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (full_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state   <= rx_next;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                end
                RX_START: clk_cnt <= half_tick ? '0 : clk_cnt + 1'b1;
                RX_BITS: begin
                    if (full_tick) begin
                        clk_cnt <= '0;
                        rx_byte <= {rx_s2, rx_byte[7:1]};  // LSB first
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (full_tick) begin
                        clk_cnt    <= '0;
                        byte_valid <= rx_s2;
                        frame_err  <= ~rx_s2;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: clk_cnt <= '0;
            endcase
        end
    end

    // ---------------- Loader FSM ----------------
    ld_state_t   ld_state, ld_next;
    logic [1:0]  byte_idx;
    logic [31:0] len;
    logic [23:0] word_reg;   // first three bytes of the word being assembled
    logic [7:0]  csum;

    wire [31:0] len_next  = {rx_byte, len[31:8]};
    wire        last_word = (({17'd0, WordCount} + 32'd1) == len);
    wire        armable   = (ld_state == IDLE) || (ld_state == DONE) || (ld_state == ERR);

    always_comb begin
        ld_next = ld_state;
        case (ld_state)
            IDLE, DONE, ERR: if (Start) ld_next = LEN;
            LEN: begin
                if (frame_err)
                    ld_next = ERR;
                else if (byte_valid && byte_idx == 2'd3)
                    ld_next = (len_next == 32'd0 || len_next > 32'(MAX_WORDS)) ? ERR : DATA;
            end
            DATA: begin
                if (frame_err)
                    ld_next = ERR;
                else if (EnableWriteOut && last_word)
                    ld_next = CSUM;
            end
            CSUM: begin
                if (frame_err)
                    ld_next = ERR;
                else if (byte_valid)
                    ld_next = (rx_byte == csum) ? DONE : ERR;
            end
            default: ld_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_state       <= IDLE;
            byte_idx       <= '0;
            len            <= '0;
            word_reg       <= '0;
            csum           <= '0;
            AddressOut     <= '0;
            WriteDataOut   <= '0;
            EnableWriteOut <= 1'b0;
            WordCount      <= '0;
        end else begin
            ld_state       <= ld_next;
            EnableWriteOut <= 1'b0;
            if (armable && Start) begin
                // Any byte completing in this cycle is dropped on purpose.
                byte_idx  <= '0;
                len       <= '0;
                csum      <= '0;
                WordCount <= '0;
            end else begin
                case (ld_state)
                    LEN: if (byte_valid) begin
                        len      <= len_next;
                        byte_idx <= byte_idx + 2'd1;
                    end
                    DATA: begin
                        if (byte_valid) begin
                            word_reg <= {rx_byte, word_reg[23:8]};
                            csum     <= csum ^ rx_byte;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                EnableWriteOut <= 1'b1;
                                WriteDataOut   <= {rx_byte, word_reg};
                                AddressOut     <= BASE_ADDR + {15'd0, WordCount, 2'b00};
                            end
                        end
                        if (EnableWriteOut) WordCount <= WordCount + 15'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Busy  = (ld_state == LEN) || (ld_state == DATA) || (ld_state == CSUM);
    assign Done  = (ld_state == DONE);
    assign Error = (ld_state == ERR);
endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader: expected writes are queued when an
// image is sent and popped by a strobe monitor; status is checked after each load.
module tb_uart_mem_loader;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        Rx;
    logic        Start;
    logic [31:0] AddressOut, WriteDataOut;
    logic        EnableWriteOut, Busy, Done, Error;
    logic [14:0] WordCount;

    int n_tests = 0;
    int n_fail  = 0;
    int nwr     = 0;
    int nwr0;
    logic [63:0] exp_q[$];

    uart_mem_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0), .MAX_WORDS(16384)) dut (
        .clk(clk), .reset(reset), .Rx(Rx), .Start(Start),
        .AddressOut(AddressOut), .WriteDataOut(WriteDataOut),
        .EnableWriteOut(EnableWriteOut), .Busy(Busy), .Done(Done),
        .Error(Error), .WordCount(WordCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write scoreboard: every strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (reset && EnableWriteOut) begin
            logic [63:0] e;
            nwr++;
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", {AddressOut, WriteDataOut}, 64'hx);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {32'd0, AddressOut}, {32'd0, e[63:32]});
                chk("wr_data", {32'd0, WriteDataOut}, {32'd0, e[31:0]});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) Rx = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) Rx = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk) Rx = stop;
        repeat (CPB - 1) @(negedge clk);
        @(negedge clk) Rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i], 1'b1);
    endtask

    task automatic pulse_start();
        @(negedge clk) Start = 1'b1;
        @(negedge clk) Start = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic d, input logic e,
                              input logic b, input int wc);
        repeat (4) @(negedge clk);
        chk({tag, "_done"}, {63'd0, Done}, {63'd0, d});
        chk({tag, "_error"}, {63'd0, Error}, {63'd0, e});
        chk({tag, "_busy"}, {63'd0, Busy}, {63'd0, b});
        chk({tag, "_wcount"}, {49'd0, WordCount}, 64'(wc));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, {32'd0, AddressOut}, 64'd0);
        chk({tag, "_wdata"}, {32'd0, WriteDataOut}, 64'd0);
        chk({tag, "_flags"}, {60'd0, EnableWriteOut, Busy, Done, Error}, 64'd0);
        chk({tag, "_wcount"}, {49'd0, WordCount}, 64'd0);
    endtask

    task automatic queue_image1();
        exp_q.push_back({32'h0000_0000, 32'h1122_3344});
        exp_q.push_back({32'h0000_0004, 32'hAABB_CCDD});
    endtask

    initial begin
        reset = 1'b0;
        Rx    = 1'b1;
        Start = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Bytes in IDLE without Start: no writes, no state change.
        nwr0 = nwr;
        send_bytes('{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11});
        chk_status("idle_bytes", 1'b0, 1'b0, 1'b0, 0);
        chk("idle_no_wr", 64'(nwr - nwr0), 64'd0);

        // Normal load.
        pulse_start();
        repeat (2) @(negedge clk);
        chk("load_busy", {63'd0, Busy}, 64'd1);
        queue_image1();
        nwr0 = nwr;
        send_bytes('{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                     8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44});
        chk_status("normal", 1'b1, 1'b0, 1'b0, 2);
        chk("normal_nwr", 64'(nwr - nwr0), 64'd2);

        // Bad checksum: writes still happen, then Error.
        pulse_start();
        repeat (2) @(negedge clk);
        chk("restart_done_clr", {63'd0, Done}, 64'd0);
        queue_image1();
        send_bytes('{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                     8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h45});
        chk_status("bad_csum", 1'b0, 1'b1, 1'b0, 2);

        // Length N=0.
        nwr0 = nwr;
        pulse_start();
        send_bytes('{8'h00, 8'h00, 8'h00, 8'h00});
        chk_status("len0", 1'b0, 1'b1, 1'b0, 0);
        // Length N=16385.
        pulse_start();
        send_bytes('{8'h01, 8'h40, 8'h00, 8'h00});
        chk_status("len16385", 1'b0, 1'b1, 1'b0, 0);
        // Length N=16384 is accepted; a framing error then aborts it.
        pulse_start();
        send_bytes('{8'h00, 8'h40, 8'h00, 8'h00});
        chk_status("len16384", 1'b0, 1'b0, 1'b1, 0);
        send_byte(8'h55, 1'b0);
        chk_status("len16384_ferr", 1'b0, 1'b1, 1'b0, 0);
        chk("len_no_wr", 64'(nwr - nwr0), 64'd0);

        // Framing error on the 3rd data byte.
        nwr0 = nwr;
        pulse_start();
        send_bytes('{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33});
        send_byte(8'h22, 1'b0);
        chk_status("frame_err", 1'b0, 1'b1, 1'b0, 0);
        chk("frame_no_wr", 64'(nwr - nwr0), 64'd0);

        // Reset after 5 data bytes: one word written, then async abort.
        pulse_start();
        exp_q.push_back({32'h0000_0000, 32'h1122_3344});
        send_bytes('{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD});
        chk("midload_wcount", {49'd0, WordCount}, 64'd1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 chk_reset_vals("async_reset");
        chk("reset_q_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        pulse_start();
        queue_image1();
        send_bytes('{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                     8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44});
        chk_status("after_reset", 1'b1, 1'b0, 1'b0, 2);

        // 3-cycle low glitch during LEN must not produce a byte.
        pulse_start();
        @(negedge clk) Rx = 1'b0;
        repeat (3) @(negedge clk);
        Rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        exp_q.push_back({32'h0000_0000, 32'h1234_5678});
        send_bytes('{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08});
        chk_status("glitch", 1'b1, 1'b0, 1'b0, 1);
        chk("final_q_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #5000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
